// File: rtl/skl_pkg.sv
// Shared definitions for the sliced Sklansky arithmetic blocks.
package skl_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/skl8.sv
// 8-bit Sklansky parallel-prefix adder: s = x1 + x2 + cin, cout = carry out.
module skl8
   import skl_pkg::*;
(
   input  logic [SLICE_W-1:0] x1,
   input  logic [SLICE_W-1:0] x2,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   // One Sklansky level: bits whose lv-th index bit is set absorb the group
   // ending just below their aligned 2^lv block. Returns {g, p}.
   function automatic logic [2*SLICE_W-1:0] sk_level(input logic [SLICE_W-1:0] g,
                                                      input logic [SLICE_W-1:0] p,
                                                      input int lv);
      logic [SLICE_W-1:0] gn;
      logic [SLICE_W-1:0] pn;
      int j;
      gn = g;
      pn = p;
      for (int i = 0; i < SLICE_W; i++) begin
         if (((i >> lv) & 1) == 1) begin
            j = ((i >> lv) << lv) - 1;
            gn[i] = g[i] | (p[i] & g[j]);
            pn[i] = p[i] & p[j];
         end
      end
      return {gn, pn};
   endfunction

   logic [SLICE_W-1:0] g0, p0, g1, p1, g2, p2, g3, p3;
   logic [SLICE_W:0]   c;

   assign g0 = x1 & x2;
   assign p0 = x1 ^ x2;
   assign {g1, p1} = sk_level(g0, p0, 0);
   assign {g2, p2} = sk_level(g1, p1, 1);
   assign {g3, p3} = sk_level(g2, p2, 2);

   // Carry into each bit from the prefix group [0..i] and the slice carry-in.
   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         c[i+1] = g3[i] | (p3[i] & cin);
      end
   end

   assign s    = p0 ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];

endmodule

// File: rtl/skl_32_sub_seq8.sv
// Multi-cycle subtractor: d = x1 - x2 - bin, one 8-bit slice per clock
// through a single shared skl8, evaluated as x1 + ~x2 + ~bin.
module skl_32_sub_seq8
   import skl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

   state_t                            state;
   logic [IDX_W-1:0]                  idx;
   logic [NSLICE-1:0][SLICE_W-1:0]    x1_r;
   logic [NSLICE-1:0][SLICE_W-1:0]    x2_r;
   logic [NSLICE-1:0][SLICE_W-1:0]    dw;
   logic [NSLICE-1:0][SLICE_W-1:0]    dw_nxt;
   logic [NSLICE-1:0][SLICE_W-1:0]    d_r;
   logic                              carry;
   logic                              bout_r;
   logic [SLICE_W-1:0]                sum;
   logic                              cout;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign d         = d_r;
   assign bout      = bout_r;

   skl8 u_skl8 (
      .x1   (x1_r[idx]),
      .x2   (~x2_r[idx]),
      .cin  (carry),
      .s    (sum),
      .cout (cout)
   );

   // Working difference with the current slice merged in; the last slice
   // loads d straight from this so d sees the complete result.
   always_comb begin
      dw_nxt      = dw;
      dw_nxt[idx] = sum;
   end

   // Control FSM, operand capture, slice writeback and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         x1_r   <= '0;
         x2_r   <= '0;
         dw     <= '0;
         carry  <= 1'b0;
         d_r    <= '0;
         bout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x1_r  <= x1;
                  x2_r  <= x2;
                  carry <= ~bin;
                  dw    <= '0;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               dw    <= dw_nxt;
               carry <= cout;
               if (idx == LAST) begin
                  d_r    <= dw_nxt;
                  bout_r <= ~cout;
                  idx    <= '0;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/skl_32_sub_seq8.md
# skl_32_sub_seq8

Multi-cycle unsigned subtractor, the inverse operation of the 8-bit-sliced Sklansky adder chain. It computes `x1 - x2 - bin` over WIDTH bits. It uses one shared 8-bit Sklansky adder, time-multiplexed across slices: one slice per clock, with the borrow carried in a register between cycles. Operands enter and results leave through valid/ready handshakes, so the block drops into datapaths where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8 (NSLICE = WIDTH/8, default 4).
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- x1  input  WIDTH  minuend.
- x2  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this cycle.
- d  output  WIDTH  difference, (x1 - x2 - bin) mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff x1 < x2 + bin (unsigned).

## Operation
- The arithmetic identity is `x1 + ~x2 + ~bin`.
  - The internal carry is initialised to `~bin`.
  - Slice k computes `x1[8k+7:8k] + ~x2[8k+7:8k] + carry`.
  - `bout = ~carry_out` of the last slice.
- The FSM has three states: IDLE, RUN, DONE.
  - **IDLE**: in_ready=1. On in_valid, capture x1, x2 and ~bin into working registers, clear the working difference, set idx=0, and go to RUN.
  - **RUN**: in_ready=0. Each cycle, write the slice idx sum into working-difference bits [8idx+7:8idx], register the slice carry, and increment idx. When idx==NSLICE-1 the last slice is computed, d and bout are loaded from the working result, and the FSM goes to DONE.
  - **DONE**: out_valid=1, in_ready=0. On out_ready, go to IDLE.
- in_ready is a pure decode of state==IDLE. out_valid is a pure decode of state==DONE.
- in_valid and operand changes while in RUN or DONE are ignored; the captured operands are unaffected.
- d and bout change only on the edge that enters DONE. They hold that value afterwards, including through IDLE and the next RUN, until the next DONE entry.
- Arithmetic wraps modulo 2^WIDTH. There is no signed interpretation and no overflow flag.

## Timing
- Reset (async, immediate) sets:
  - state to IDLE, so in_ready=1 and out_valid=0;
  - d=0, bout=0;
  - idx=0, working registers =0.
- Reset mid-RUN or mid-DONE discards the operation. No out_valid follows.
- Let edge T be the accept edge (in_valid & in_ready).
  - RUN slices are computed on edges T+1 … T+NSLICE.
  - out_valid rises after edge T+NSLICE (T+4 by default).
- The output handshake completes on the first edge where out_valid & out_ready; the FSM is in IDLE after that edge.
- Minimum initiation interval is NSLICE+2 cycles (6 by default), achieved when out_ready is held high.
- With out_ready low, DONE is held indefinitely: d, bout and out_valid are stable and in_ready stays 0.

## Structure
- Shared package skl_pkg holds:
  - the state encoding constants (IDLE/RUN/DONE);
  - SLICE_W=8;
  - a clog2 helper for the idx width.
- One sub-module: the existing skl8 adder, instantiated exactly once.
  - cin is driven from the carry register.
  - x2 is driven from the inverted operand slice selected by idx.
- All control, operand slicing and result writeback stay in skl_32_sub_seq8.

## Test plan
- **Reset**: assert rst mid-cycle. in_ready=1, out_valid=0, d=0, bout=0 must hold immediately, without waiting for a clock edge.
- **Basic subtract**: x1=0x00000005, x2=0x00000003, bin=0 → d=0x00000002, bout=0. out_valid must rise exactly 4 edges after the accept edge.
- **Full borrow ripple**: x1=0x00000000, x2=0x00000001, bin=0 → d=0xFFFFFFFF, bout=1.
- **Borrow-in**:
  - x1=x2=0x12345678, bin=1 → d=0xFFFFFFFF, bout=1.
  - Same operands with bin=0 → d=0x00000000, bout=0.
- **Backpressure**: hold out_ready=0 for 10 cycles after DONE while toggling in_valid and operands.
  - d, bout and out_valid must stay stable and in_ready=0 throughout.
  - After release, the next operation is accepted 1 cycle later.
- **Abort and throughput**:
  - Assert rst during the third RUN cycle → out_valid never rises, and the next operation after reset is correct.
  - Send back-to-back operations with out_ready=1 → accept edges exactly 6 cycles apart, with results matching a reference model over 1000 random operands.
